// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage behind the REG1/REG2 datapath.
// Accepts one operand pair and an opcode over valid/ready, computes a single
// result (single-cycle ops, or a WIDTH-iteration shift-add multiply), and
// holds the registered result and flags until downstream takes it.
// rst_n is active-high: asserted = 1.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [2:0]           opcode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           state
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL  = 3'd2,
    DONE = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  state_t               st;
  op_t                  op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [SW-1:0]        cnt;

  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   exec_res;
  logic                 exec_z;
  logic                 exec_c;
  logic                 exec_v;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     diff;
  logic                 lt;
  logic [2*WIDTH-1:0]   shl;

  assign state     = st;
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);

  // Accumulator value after the current multiply iteration
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Single-cycle result and flags from the captured operands
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    sum      = {1'b0, a_r} + {1'b0, b_r};
    diff     = a_r - b_r;
    lt       = (a_r < b_r);
    shl      = {{WIDTH{1'b0}}, a_r} << b_r[SW-1:0];
    case (op_r)
      OP_ADD: begin
        exec_res = {{(WIDTH-1){1'b0}}, sum};
        exec_c   = sum[WIDTH];
        exec_v   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = {{WIDTH{1'b0}}, diff};
        exec_c   = lt;
        exec_v   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: exec_res = {{WIDTH{1'b0}}, a_r & b_r};
      OP_OR:  exec_res = {{WIDTH{1'b0}}, a_r | b_r};
      OP_XOR: exec_res = {{WIDTH{1'b0}}, a_r ^ b_r};
      OP_SHL: exec_res = shl;
      OP_CMP: begin
        exec_res = {{(2*WIDTH-1){1'b0}}, lt};
        exec_c   = lt;
      end
      default: exec_res = '0;
    endcase
    exec_z = (op_r == OP_CMP) ? (a_r == b_r) : (exec_res == '0);
  end

  // Control FSM, operand capture, multiply iterations and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st         <= IDLE;
      op_r       <= OP_ADD;
      a_r        <= '0;
      b_r        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            a_r  <= op_a;
            b_r  <= op_b;
            op_r <= op_t'(opcode);
            st   <= EXEC;
          end
        end
        EXEC: begin
          if (op_r == OP_MUL) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_r};
            mplier <= b_r;
            st     <= MUL;
          end else begin
            result     <= exec_res;
            flag_zero  <= exec_z;
            flag_carry <= exec_c;
            flag_ovf   <= exec_v;
            st         <= DONE;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration publishes acc_next directly so DONE follows at once
          if (cnt == SW'(WIDTH - 1)) begin
            result     <= acc_next;
            flag_zero  <= (acc_next == '0);
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            st         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit with a latency-level
// reference model compared against the DUT on every falling edge.
module tb_alu_exec_unit;

  localparam int W = 4;

  typedef struct packed {
    logic [2*W-1:0] r;
    logic           z;
    logic           c;
    logic           v;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic [2:0]     opcode = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] result;
  logic           flag_zero;
  logic           flag_carry;
  logic           flag_ovf;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2:0]     state;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for one operation, from plain integer math
  function automatic exp_t calc(input int a, input int b, input int op);
    exp_t e;
    int full, sa, sb, s;
    e    = '0;
    full = 0;
    s    = 0;
    sa   = (a >= 2**(W-1)) ? a - 2**W : a;
    sb   = (b >= 2**(W-1)) ? b - 2**W : b;
    case (op)
      0: begin
        full = a + b;
        e.c  = (full >= 2**W);
        s    = sa + sb;
        e.v  = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
      end
      1: begin
        full = (a - b + 2**W) % (2**W);
        e.c  = (a < b);
        s    = sa - sb;
        e.v  = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
      end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = a * (2**(b % W));
      6: full = a * b;
      default: begin
        full = (a < b) ? 1 : 0;
        e.c  = (a < b);
      end
    endcase
    e.r = (2*W)'(full);
    e.z = (op == 7) ? (a == b) : (full == 0);
    return e;
  endfunction

  // Latency model: busy for 1 edge (or W+1 for MUL) after accept, then done
  logic m_idle = 1'b1;
  logic m_done = 1'b0;
  int   m_left = 0;
  int   m_acc  = 0;
  int   ma = 0, mb = 0, mop = 0;
  exp_t m_res = '0;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_idle <= 1'b1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= calc(ma, mb, mop);
      end
    end else if (m_idle && in_valid) begin
      m_idle <= 1'b0;
      m_left <= (opcode == 3'd6) ? W + 1 : 1;
      m_acc  <= m_acc + 1;
      ma     <= int'(op_a);
      mb     <= int'(op_b);
      mop    <= int'(opcode);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
    chk("result", {24'd0, result}, {24'd0, m_res.r});
    chk("flag_zero", {31'd0, flag_zero}, {31'd0, m_res.z});
    chk("flag_carry", {31'd0, flag_carry}, {31'd0, m_res.c});
    chk("flag_ovf", {31'd0, flag_ovf}, {31'd0, m_res.v});
    if (m_idle)      chk("state idle", {29'd0, state}, 32'd0);
    else if (m_done) chk("state done", {29'd0, state}, 32'd3);
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int k;
    @(negedge clk);
    op_a = a; op_b = b; opcode = op; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    opcode = 3'($urandom);
  endtask

  // Counts edges from accept (edge 1) until out_valid is seen
  task automatic wait_done(output int edges);
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      chk("busy in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!out_valid) chk("done timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [7:0] er, input logic ez,
                       input logic ec, input logic ev, input int elat);
    int e;
    send(a, b, op);
    wait_done(e);
    chk({name, " latency"}, e, elat);
    chk({name, " result"}, {24'd0, result}, {24'd0, er});
    chk({name, " flags"}, {29'd0, flag_zero, flag_carry, flag_ovf}, {29'd0, ez, ec, ev});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, base;
    bit seen;

    // Hand-computed pins on the reference model
    chk("pin add 9+8", 32'(calc(9, 8, 0)), 32'({8'h11, 1'b0, 1'b1, 1'b1}));
    chk("pin sub 3-5", 32'(calc(3, 5, 1)), 32'({8'h0E, 1'b0, 1'b1, 1'b0}));
    chk("pin sub 8-1", 32'(calc(8, 1, 1)), 32'({8'h07, 1'b0, 1'b0, 1'b1}));
    chk("pin mul 15*15", 32'(calc(15, 15, 6)), 32'({8'hE1, 1'b0, 1'b0, 1'b0}));
    chk("pin shl B<<3", 32'(calc(11, 3, 5)), 32'({8'h58, 1'b0, 1'b0, 1'b0}));
    chk("pin cmp 5,5", 32'(calc(5, 5, 7)), 32'({8'h00, 1'b1, 1'b0, 1'b0}));

    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset in_ready/out_valid", {30'd0, in_ready, out_valid}, 32'd2);
    chk("reset result", {24'd0, result}, 32'd0);
    chk("reset flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    do_op("add 9+8", 4'd9, 4'd8, 3'b000, 8'h11, 1'b0, 1'b1, 1'b1, 2);
    do_op("sub 3-5", 4'd3, 4'd5, 3'b001, 8'h0E, 1'b0, 1'b1, 1'b0, 2);
    do_op("cmp 5,5", 4'd5, 4'd5, 3'b111, 8'h00, 1'b1, 1'b0, 1'b0, 2);
    do_op("cmp 2,9", 4'd2, 4'd9, 3'b111, 8'h01, 1'b0, 1'b1, 1'b0, 2);
    do_op("add 7+1", 4'd7, 4'd1, 3'b000, 8'h08, 1'b0, 1'b0, 1'b1, 2);
    do_op("sub 8-1", 4'd8, 4'd1, 3'b001, 8'h07, 1'b0, 1'b0, 1'b1, 2);
    do_op("xor 5^5", 4'd5, 4'd5, 3'b100, 8'h00, 1'b1, 1'b0, 1'b0, 2);
    do_op("mul 15*15", 4'd15, 4'd15, 3'b110, 8'hE1, 1'b0, 1'b0, 1'b0, 6);
    do_op("mul 0*7", 4'd0, 4'd7, 3'b110, 8'h00, 1'b1, 1'b0, 1'b0, 6);
    do_op("mul 13*6", 4'd13, 4'd6, 3'b110, 8'h4E, 1'b0, 1'b0, 1'b0, 6);

    // Backpressure on SHL with stray in_valid pulses
    @(negedge clk);
    out_ready = 1'b0;
    do_op("shl B<<3", 4'hB, 4'd3, 3'b101, 8'h58, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op_a = 4'd1; op_b = 4'd2; opcode = 3'b000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold result", {24'd0, result}, 32'h58);
      chk("hold state", {29'd0, state}, 32'd3);
      chk("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release state", {29'd0, state}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    send(4'd3, 4'd5, 3'b110);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid-mul state", {29'd0, state}, 32'd2);
    rst_n = 1'b1;
    #1;
    chk("async rst state", {29'd0, state}, 32'd0);
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst result", {24'd0, result}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    do_op("add 1+1", 4'd1, 4'd1, 3'b000, 8'h02, 1'b0, 1'b0, 1'b0, 2);

    // Back-to-back with in_valid held high
    base = m_acc;
    @(negedge clk);
    op_a = 4'hC; op_b = 4'hA; opcode = 3'b010; in_valid = 1'b1;
    e = 0;
    while (!in_ready && e < 50) begin
      @(negedge clk);
      e++;
    end
    @(posedge clk);
    #1;
    opcode = 3'b011;
    e = 1;
    seen = 1'b0;
    while (m_acc < base + 2 && e < 60) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        chk("b2b and result", {24'd0, result}, 32'h08);
        seen = 1'b1;
      end
      @(posedge clk);
      #1;
      e++;
    end
    in_valid = 1'b0;
    chk("b2b first delivered", {31'd0, seen}, 32'd1);
    chk("b2b second accept edge", e, 32'd4);
    chk("b2b state after accept", {29'd0, state}, 32'd1);
    wait_done(e);
    chk("b2b or latency", e, 32'd2);
    chk("b2b or result", {24'd0, result}, 32'h0E);
    repeat (3) @(negedge clk);
    chk("b2b idle after", {29'd0, state, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
